// File: rtl/glyph_renderer.sv
// Character glyph rasteriser: fetches a font bitmap per draw command and streams
// scaled fg/bg pixel writes in screen raster order, honouring output backpressure.
module glyph_renderer #(
    parameter int GLYPH_W     = 8,
    parameter int GLYPH_H     = 16,
    parameter int SCALE       = 1,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOR_W     = 3,
    parameter int TRANSPARENT = 0
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_char,
    input  logic [X_W-1:0]             in_x,
    input  logic [Y_W-1:0]             in_y,
    input  logic [COLOR_W-1:0]         in_fg,
    input  logic [COLOR_W-1:0]         in_bg,
    output logic [6:0]                 font_char,
    input  logic [GLYPH_W*GLYPH_H-1:0] font_bits,
    output logic                       plot,
    input  logic                       out_ready,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y,
    output logic [COLOR_W-1:0]         out_color,
    output logic                       busy,
    output logic                       done
);
    localparam int NB = GLYPH_W * GLYPH_H;
    localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
    } cmd_t;

    logic [1:0]     state;
    cmd_t           cmd;
    logic [NB-1:0]  bitmap;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [SW-1:0]  sx, sy;
    logic [X_W-1:0] x_acc;     // col*SCALE
    logic [Y_W-1:0] y_acc;     // row*SCALE
    logic [BW-1:0]  row_base;  // bitmap index of column 0 in the current row

    logic drawing, pix_bit, advance;
    logic last_sx, last_col, last_sy, last_row;

    assign drawing  = (state == S_DRAW);
    assign pix_bit  = bitmap[row_base - BW'(col)];
    assign plot     = drawing && (pix_bit || (TRANSPARENT == 0));
    assign advance  = drawing && (!plot || out_ready);
    assign last_sx  = (sx  == SW'(SCALE - 1));
    assign last_col = (col == CW'(GLYPH_W - 1));
    assign last_sy  = (sy  == SW'(SCALE - 1));
    assign last_row = (row == RW'(GLYPH_H - 1));

    assign in_ready  = (state == S_IDLE);
    assign busy      = !in_ready;
    assign out_x     = drawing ? cmd.x + x_acc + X_W'(sx) : '0;
    assign out_y     = drawing ? cmd.y + y_acc + Y_W'(sy) : '0;
    assign out_color = drawing ? (pix_bit ? cmd.fg : cmd.bg) : '0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cmd       <= '0;
            bitmap    <= '0;
            font_char <= 7'h20;
            col       <= '0;
            row       <= '0;
            sx        <= '0;
            sy        <= '0;
            x_acc     <= '0;
            y_acc     <= '0;
            row_base  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cmd       <= '{x: in_x, y: in_y, fg: in_fg, bg: in_bg};
                        font_char <= in_char;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    bitmap   <= font_bits;
                    col      <= '0;
                    row      <= '0;
                    sx       <= '0;
                    sy       <= '0;
                    x_acc    <= '0;
                    y_acc    <= '0;
                    row_base <= BW'(NB - 1);
                    state    <= S_DRAW;
                end
                S_DRAW: begin
                    if (advance) begin
                        // nested wrap: sx -> col -> sy -> row
                        if (!last_sx) begin
                            sx <= sx + SW'(1);
                        end else begin
                            sx <= '0;
                            if (!last_col) begin
                                col   <= col + CW'(1);
                                x_acc <= x_acc + X_W'(SCALE);
                            end else begin
                                col   <= '0;
                                x_acc <= '0;
                                if (!last_sy) begin
                                    sy <= sy + SW'(1);
                                end else begin
                                    sy <= '0;
                                    if (!last_row) begin
                                        row      <= row + RW'(1);
                                        y_acc    <= y_acc + Y_W'(SCALE);
                                        row_base <= row_base - BW'(GLYPH_W);
                                    end else begin
                                        state <= S_IDLE;
                                        done  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_glyph_renderer.sv
// Bench for glyph_renderer: three instances (default, SCALE=2, TRANSPARENT=1)
// share stimulus; a scoreboard queue holds expected pixel writes.
module tb_glyph_renderer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, out_ready;
    logic [6:0] in_char;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_fg, in_bg;

    logic         in_valid [3];
    logic         in_ready_v [3], plot_v [3], busy_v [3], done_v [3];
    logic [7:0]   ox [3];
    logic [6:0]   oy [3];
    logic [2:0]   oc [3];
    logic [6:0]   fch [3];
    logic [127:0] fbits [3];

    function automatic logic [127:0] font(input logic [6:0] c);
        logic [127:0] f;
        logic [7:0]   r;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            case (c)
                7'h20:   r = 8'h00;
                7'h48:   r = (i >= 2 && i <= 12) ? ((i == 7) ? 8'hFE : 8'hC6) : 8'h00;
                default: r = 8'(c * (i + 3)) ^ 8'(i * 29);
            endcase
            f[127 - 8*i -: 8] = r;
        end
        return f;
    endfunction

    assign fbits[0] = font(fch[0]);
    assign fbits[1] = font(fch[1]);
    assign fbits[2] = font(fch[2]);

    glyph_renderer u_def (
        .clock(clock), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
        .in_char(in_char), .in_x(in_x), .in_y(in_y), .in_fg(in_fg), .in_bg(in_bg),
        .font_char(fch[0]), .font_bits(fbits[0]), .plot(plot_v[0]), .out_ready(out_ready),
        .out_x(ox[0]), .out_y(oy[0]), .out_color(oc[0]), .busy(busy_v[0]), .done(done_v[0]));

    glyph_renderer #(.SCALE(2)) u_s2 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
        .in_char(in_char), .in_x(in_x), .in_y(in_y), .in_fg(in_fg), .in_bg(in_bg),
        .font_char(fch[1]), .font_bits(fbits[1]), .plot(plot_v[1]), .out_ready(out_ready),
        .out_x(ox[1]), .out_y(oy[1]), .out_color(oc[1]), .busy(busy_v[1]), .done(done_v[1]));

    glyph_renderer #(.TRANSPARENT(1)) u_tr (
        .clock(clock), .resetn(resetn), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
        .in_char(in_char), .in_x(in_x), .in_y(in_y), .in_fg(in_fg), .in_bg(in_bg),
        .font_char(fch[2]), .font_bits(fbits[2]), .plot(plot_v[2]), .out_ready(out_ready),
        .out_x(ox[2]), .out_y(oy[2]), .out_color(oc[2]), .busy(busy_v[2]), .done(done_v[2]));

    int         sel;
    logic       plot, busy, done, in_ready;
    logic [7:0] out_x;
    logic [6:0] out_y, font_char;
    logic [2:0] out_color;
    always_comb begin
        plot      = plot_v[sel];
        busy      = busy_v[sel];
        done      = done_v[sel];
        in_ready  = in_ready_v[sel];
        out_x     = ox[sel];
        out_y     = oy[sel];
        out_color = oc[sel];
        font_char = fch[sel];
    end

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;
    pix_t q[$];

    int total = 0, bad = 0;
    int cap_idx, exp_cnt;
    logic [7:0] cap_x;
    logic [6:0] cap_y;
    logic [2:0] cap_c;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Expected writes in raster order, straight from the glyph geometry.
    task automatic build(input logic [6:0] ch, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] fg, input logic [2:0] bg);
        logic [127:0] f;
        int sc;
        bit tr, b;
        f  = font(ch);
        sc = (sel == 1) ? 2 : 1;
        tr = (sel == 2);
        for (int r = 0; r < 16; r++)
            for (int yy = 0; yy < sc; yy++)
                for (int c = 0; c < 8; c++)
                    for (int xx = 0; xx < sc; xx++) begin
                        b = f[(15 - r)*8 + 7 - c];
                        if (!tr || b)
                            q.push_back('{x: 8'(x + c*sc + xx), y: 7'(y + r*sc + yy), c: b ? fg : bg});
                    end
        exp_cnt = q.size();
    endtask

    task automatic run(input logic [6:0] ch, input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] fg, input logic [2:0] bg, input bit toggle,
                       input int abort_cyc, output int lat, output int nplots);
        pix_t e;
        bit stall;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        int pidx;
        build(ch, x, y, fg, bg);
        chk("in_ready_before_cmd", int'(in_ready), 1);
        in_char = ch; in_x = x; in_y = y; in_fg = fg; in_bg = bg;
        in_valid[sel] = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid[sel] = 1'b0;
        in_char = 7'h7f; in_x = 8'hff; in_y = 7'h7f; in_fg = 3'h1; in_bg = 3'h6;
        lat = -1; nplots = 0; pidx = 0; stall = 0;
        px = '0; py = '0; pc = '0;
        for (int cyc = 1; cyc < 5000; cyc++) begin
            @(negedge clock);
            out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (cyc == 1) begin
                chk("fetch_busy", int'(busy), 1);
                chk("fetch_in_ready", int'(in_ready), 0);
            end
            if (stall) chk("stall_hold", int'({plot, out_x, out_y, out_color}), int'({1'b1, px, py, pc}));
            if (plot && out_ready) begin
                nplots++;
                if (q.size() == 0) chk("unexpected_plot", nplots, exp_cnt);
                else begin
                    e = q.pop_front();
                    chk("pixel_xyc", int'({out_x, out_y, out_color}), int'({e.x, e.y, e.c}));
                end
                if (pidx == cap_idx) begin cap_x = out_x; cap_y = out_y; cap_c = out_color; end
                pidx++;
            end
            stall = plot && !out_ready;
            px = out_x; py = out_y; pc = out_color;
            if (done) begin lat = cyc; break; end
            if (cyc == abort_cyc) begin
                resetn = 1'b0;
                @(negedge clock);
                #1;
                chk("abort_plot", int'(plot), 0);
                chk("abort_in_ready", int'(in_ready), 1);
                chk("abort_done", int'(done), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_font_char", int'(font_char), 32);
                resetn = 1'b1;
                q.delete();
                lat = 0;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", lat, 0);
        else if (abort_cyc < 0) chk("queue_empty", q.size(), 0);
    endtask

    typedef struct {
        logic [6:0] ch;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] fg, bg;
        int plots, lat;
    } vec_t;
    vec_t tbl[4];

    initial begin
        int lat, np;
        tbl[0] = '{ch: 7'h48, x: 8'd10,  y: 7'd20, fg: 3'd7, bg: 3'd0, plots: 128, lat: 130};
        tbl[1] = '{ch: 7'h42, x: 8'd100, y: 7'd50, fg: 3'd3, bg: 3'd5, plots: 128, lat: 130};
        tbl[2] = '{ch: 7'h30, x: 8'd0,   y: 7'd0,  fg: 3'd1, bg: 3'd2, plots: 128, lat: 130};
        tbl[3] = '{ch: 7'h7a, x: 8'd200, y: 7'd100, fg: 3'd6, bg: 3'd4, plots: 128, lat: 130};

        sel = 0; cap_idx = -1;
        resetn = 1'b0; out_ready = 1'b1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0; in_valid[2] = 1'b0;
        in_char = '0; in_x = '0; in_y = '0; in_fg = '0; in_bg = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_font_char", int'(font_char), 32);
        chk("rst_out_xyc", int'({out_x, out_y, out_color}), 0);
        resetn = 1'b1;

        // Back-to-back commands on the default instance; the first is 'H'.
        cap_idx = 32;
        for (int i = 0; i < 4; i++) begin
            run(tbl[i].ch, tbl[i].x, tbl[i].y, tbl[i].fg, tbl[i].bg, 1'b0, -1, lat, np);
            chk("tbl_plots", np, tbl[i].plots);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_font_char", int'(font_char), int'(tbl[i].ch));
            if (i == 0) begin
                chk("H_row4_x", int'(cap_x), 10);
                chk("H_row4_y", int'(cap_y), 24);
                chk("H_row4_color", int'(cap_c), 7);
                cap_idx = -1;
            end
        end

        // SCALE=2 'I'
        sel = 1; cap_idx = 511;
        @(negedge clock);
        run(7'h49, 8'd0, 7'd0, 3'd2, 3'd5, 1'b0, -1, lat, np);
        chk("s2_plots", np, 512);
        chk("s2_latency", lat, 514);
        chk("s2_last_x", int'(cap_x), 15);
        chk("s2_last_y", int'(cap_y), 31);

        // TRANSPARENT space: nothing plotted, full scan time
        sel = 2; cap_idx = -1;
        @(negedge clock);
        run(7'h20, 8'd40, 7'd40, 3'd7, 3'd1, 1'b0, -1, lat, np);
        chk("tr_space_plots", np, 0);
        chk("tr_space_latency", lat, 130);
        run(7'h54, 8'd30, 7'd30, 3'd4, 3'd2, 1'b1, -1, lat, np);
        chk("tr_T_plots", np, exp_cnt);

        // Backpressure: out_ready low on every pixel's first cycle
        sel = 0;
        @(negedge clock);
        run(7'h41, 8'd60, 7'd60, 3'd5, 3'd3, 1'b1, -1, lat, np);
        chk("bp_plots", np, 128);
        chk("bp_latency", lat, 258);

        // Wrap at x=256 then reset during pixel 40
        cap_idx = 4;
        run(7'h57, 8'd252, 7'd0, 3'd7, 3'd0, 1'b0, 42, lat, np);
        chk("wrap_x", int'(cap_x), 0);
        chk("abort_plots", np, 41);
        cap_idx = -1;

        // Recovery after abort
        run(7'h4b, 8'd5, 7'd5, 3'd2, 3'd6, 1'b0, -1, lat, np);
        chk("recover_plots", np, 128);
        chk("recover_latency", lat, 130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/glyph_renderer.md
# glyph_renderer

Parametrised text-glyph rasteriser that sits between the text layer and the VGA pixel-write port. Accepts one character draw command per handshake, fetches the glyph bitmap from an external font lookup, and streams per-pixel writes (x, y, colour, plot) with optional integer scaling, foreground/background colouring, transparent background and output backpressure. Successor to the fixed 8x16 combinational glyph lookup: it adds generic glyph geometry, scaling and a sequential pixel engine.

## Interface
- GLYPH_W, 8, glyph width in pixels (>=1)
- GLYPH_H, 16, glyph height in pixels (>=1)
- SCALE, 1, integer magnification per axis (>=1)
- X_W, 8, screen x coordinate width
- Y_W, 7, screen y coordinate width
- COLOR_W, 3, colour width
- TRANSPARENT, 0, 1 = background pixels are not plotted
- clock  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  draw command valid
- in_ready  out  1  block can accept a command
- in_char  in  7  ASCII code
- in_x  in  X_W  top-left screen x
- in_y  in  Y_W  top-left screen y
- in_fg  in  COLOR_W  foreground colour
- in_bg  in  COLOR_W  background colour
- font_char  out  7  character presented to font lookup (registered)
- font_bits  in  GLYPH_W*GLYPH_H  glyph bitmap, combinational from font_char; row-major, row 0 in MSBs, column 0 = MSB of each row, 1 = foreground
- plot  out  1  pixel write valid
- out_ready  in  1  pixel sink accepts write this cycle
- out_x  out  X_W  pixel x
- out_y  out  Y_W  pixel y
- out_color  out  COLOR_W  pixel colour
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, FETCH, DRAW.
- IDLE: in_ready=1, busy=0. On in_valid: latch char, x, y, fg, bg into registers; font_char <= in_char; go FETCH.
- FETCH (exactly 1 cycle): capture font_bits into internal bitmap register; clear counters col, sx, row, sy; go DRAW.
- DRAW: current pixel = bitmap bit index (GLYPH_H-1-row)*GLYPH_W + (GLYPH_W-1-col) of vector.
  - out_x = base_x + col*SCALE + sx, out_y = base_y + row*SCALE + sy; both truncated modulo 2^X_W / 2^Y_W (wrap, no clipping).
  - out_color = fg if bit=1 else bg.
  - plot = 1 unless TRANSPARENT=1 and bit=0.
  - Advance when plot=0 or out_ready=1; hold all outputs stable while plot=1 and out_ready=0.
  - Scan order: sx fastest, then col, then sy, then row (screen raster order).
  - After the last pixel (row=GLYPH_H-1, sy=SCALE-1, col=GLYPH_W-1, sx=SCALE-1) advances: go IDLE, done=1 for that first IDLE cycle.
- font_char holds the last accepted character between commands; font_bits is sampled only in FETCH.
- Input command fields are ignored outside the accepting IDLE cycle.
- Counters sized $clog2 of their range (min 1 bit); col*SCALE computed by incremental accumulator, no multiplier/divider.

## Timing
- Reset (resetn=0 at edge): state IDLE, plot=0, busy=0, done=0, in_ready=1 next cycle, font_char=7'h20, out_x=0, out_y=0, out_color=0, counters 0. Reset mid-DRAW aborts immediately; no further plot.
- Command accepted at edge E0; FETCH during cycle E0..E1; first pixel presented (plot) in cycle after E1.
- Non-transparent, out_ready tied high: N = GLYPH_W*GLYPH_H*SCALE^2 plot cycles; total from acceptance to done = N+2 cycles; next command acceptable in the done cycle (back-to-back throughput N+2).
- Transparent skipped pixels consume one cycle each, out_ready ignored for them.
- in_ready=0 and busy=1 throughout FETCH and DRAW.

## Test plan
- Reset: hold resetn=0 two cycles -> plot=0, busy=0, done=0, in_ready=1, font_char=7'h20.
- 'H' (7'h48) at (10,20), fg=7, bg=0, defaults, out_ready=1 -> first plot 2 cycles after accept at (10,20) colour 0; 128 plots in raster order; pixel (10,24) colour 7 (row 4 = 11000110); done 130 cycles after accept.
- SCALE=2, 'I' at (0,0) -> 512 plots; each bitmap bit covers a 2x2 block; last pixel (15,31); done at cycle 514.
- TRANSPARENT=1, space (all-zero bitmap) -> zero plots, done 130 cycles after accept.
- Backpressure: toggle out_ready 0/1 each cycle during 'A' draw -> outputs stable while stalled; 128 accepted writes identical to unstalled run; done 258 cycles after accept.
- Wrap + reset mid-draw: 'W' at (252,0) -> column x=256 appears as out_x=0; assert resetn=0 at pixel 40 -> plot=0 next cycle, in_ready=1, no done pulse.
